// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_ctrl
//  Purpose  : Command/register-access sequencer between the SPI slave byte
//             interface and the control register file. The first byte of a
//             frame is a command (bit 7 = read, low bits = start address);
//             following bytes are auto-incrementing writes or reads. The
//             byte to shift out next is supplied on o_tx_data, and a commit
//             strobe follows any frame that wrote at least one register.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             i_frame_start/end   - ss assert / deassert pulses
//             i_byte_done,i_rx_data - received byte strobe and data
//             o_tx_data           - next byte to transmit (status/echo/read)
//             o_wr_en/addr/data   - register write strobe
//             o_rd_en/addr,i_rd_data - register read request, data 1 cycle later
//             o_commit            - frame-end commit pulse
//             o_err, i_clr_err    - sticky bad-command flag and its clear
//             o_active            - sequencer is inside a frame
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
    parameter int         ADDR_W    = 7,
    parameter logic [6:0] STATUS_ID = 7'h2A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    input  logic              i_byte_done,
    input  logic [7:0]        i_rx_data,
    output logic [7:0]        o_tx_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_commit,
    output logic              o_err,
    input  logic              i_clr_err,
    output logic              o_active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_READ    = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_ptr, w_ptr;
    logic                r_wrote, w_wrote;
    logic                r_commit_pend, w_commit_pend;
    logic                r_commit, w_commit;
    logic                r_wr_en, w_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
    logic [7:0]          r_wr_data, w_wr_data;
    logic                r_rd_en, w_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr;
    logic [7:0]          r_tx_data, w_tx_data;
    logic                r_err, w_err;
    logic                r_active;

    // Any set bit above the address field makes the command invalid.
    logic                w_cmd_bad;
    logic [ADDR_W-1:0]   w_cmd_addr;
    assign w_cmd_bad  = |(i_rx_data[6:0] >> ADDR_W);
    assign w_cmd_addr = i_rx_data[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_wrote       <= 1'b0;
            r_commit_pend <= 1'b0;
            r_commit      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 8'h00;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_tx_data     <= {STATUS_ID, 1'b0};
            r_err         <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_wrote       <= w_wrote;
            r_commit_pend <= w_commit_pend;
            r_commit      <= w_commit;
            r_wr_en       <= w_wr_en;
            r_wr_addr     <= w_wr_addr;
            r_wr_data     <= w_wr_data;
            r_rd_en       <= w_rd_en;
            r_rd_addr     <= w_rd_addr;
            r_tx_data     <= w_tx_data;
            r_err         <= w_err;
            r_active      <= (w_state != S_IDLE);
        end
    end

    always_comb begin
        w_state       = r_state;
        w_ptr         = r_ptr;
        w_wrote       = r_wrote;
        w_commit_pend = 1'b0;
        w_commit      = r_commit_pend;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_rd_en       = 1'b0;
        w_rd_addr     = r_rd_addr;
        w_tx_data     = r_tx_data;
        w_err         = r_err & ~i_clr_err;

        if (r_state == S_IDLE) begin
            if (i_frame_start) begin
                w_state = S_CMD;
            end
        end else if (i_frame_start) begin
            // Abrupt restart: the aborted frame never commits.
            w_state = S_CMD;
            w_wrote = 1'b0;
        end else if (i_frame_end) begin
            w_state = S_IDLE;
            w_wrote = 1'b0;
            if ((r_state == S_WRITE) && i_byte_done) begin
                // Final byte arrives with ss deassert: write it, and delay
                // the commit one cycle so it trails the write strobe.
                w_wr_en       = 1'b1;
                w_wr_addr     = r_ptr;
                w_wr_data     = i_rx_data;
                w_ptr         = r_ptr + c_ONE;
                w_commit_pend = 1'b1;
            end else begin
                w_commit = r_commit_pend | r_wrote;
            end
        end else begin
            case (r_state)
                S_CMD: begin
                    if (i_byte_done) begin
                        if (w_cmd_bad) begin
                            w_err   = 1'b1;
                            w_state = S_DISCARD;
                        end else if (!i_rx_data[7]) begin
                            w_ptr   = w_cmd_addr;
                            w_state = S_WRITE;
                        end else begin
                            w_ptr     = w_cmd_addr;
                            w_rd_en   = 1'b1;
                            w_rd_addr = w_cmd_addr;
                            w_state   = S_RD_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_byte_done) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_ptr;
                        w_wr_data = i_rx_data;
                        w_tx_data = i_rx_data;
                        w_ptr     = r_ptr + c_ONE;
                        w_wrote   = 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    // While the request strobe is still out the data is not
                    // back yet; capture on the following cycle.
                    if (!r_rd_en) begin
                        w_tx_data = i_rd_data;
                        w_ptr     = r_ptr + c_ONE;
                        w_state   = S_READ;
                    end
                end
                S_READ: begin
                    if (i_byte_done) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_ptr;
                        w_state   = S_RD_WAIT;
                    end
                end
                default: begin
                end
            endcase
        end

        // Outside data phases the transmit byte tracks the live status.
        if ((w_state == S_IDLE) || (w_state == S_CMD) || (w_state == S_DISCARD)) begin
            w_tx_data = {STATUS_ID, w_err};
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_commit  = r_commit;
    assign o_err     = r_err;
    assign o_active  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_ctrl
//  Purpose  : Randomized scoreboard bench for spi_reg_ctrl with a frame-level
//             reference model and a register-file model (ADDR_W = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fs, fe, bd, clr, tb_chk;
    logic [7:0]    rx;
    logic [7:0]    tx_data, wr_data, rd_data;
    logic          wr_en, rd_en, commit, err, active;
    logic [AW-1:0] wr_addr, rd_addr;

    int unsigned   cyc = 0;
    int unsigned   last_pulse_cyc;
    int            n_cmp = 0;
    int            n_bad = 0;

    logic [7:0]    tx_q[$];
    logic [11:0]   wr_q[$];
    logic [3:0]    rd_q[$];
    int unsigned   cq[$];

    logic [7:0]    model_regs[16];
    logic [7:0]    hw_regs[16];
    bit            model_err;
    logic [7:0]    fd[8];

    spi_reg_ctrl #(.ADDR_W(AW), .STATUS_ID(7'h2A)) dut (
        .clk(clk), .rst(rst),
        .i_frame_start(fs), .i_frame_end(fe), .i_byte_done(bd), .i_rx_data(rx),
        .o_tx_data(tx_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_commit(commit), .o_err(err), .i_clr_err(clr), .o_active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 29 + 5) & 255);
    endfunction

    // Register file environment: synchronous read, data one cycle after request.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) hw_regs[i] <= init_val(i);
            rd_data <= 8'h00;
        end else begin
            if (wr_en) hw_regs[wr_addr] <= wr_data;
            if (rd_en) rd_data <= hw_regs[rd_addr];
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] st(input bit e);
        return {7'h2A, e};
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", {31'b0, wr_en}, 32'd0);
            else chk("wr_addr_data", {20'b0, wr_addr, wr_data}, {20'b0, wr_q.pop_front()});
        end
        if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", {31'b0, rd_en}, 32'd0);
            else chk("rd_addr", {28'b0, rd_addr}, {28'b0, rd_q.pop_front()});
        end
        if (commit) begin
            if (cq.size() == 0) chk("commit_unexpected", {31'b0, commit}, 32'd0);
            else chk("commit_cycle", cyc, cq.pop_front());
        end
        if (bd && tb_chk) begin
            if (tx_q.size() == 0) chk("tx_no_expectation", {24'b0, tx_data}, 32'hFFFF);
            else chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
    end

    task automatic pulse(input bit s, input bit e, input bit b, input logic [7:0] d,
                         input bit c, input bit cl);
        fs = s; fe = e; bd = b; rx = d; tb_chk = c; clr = cl;
        last_pulse_cyc = cyc;
        @(posedge clk); #1;
        fs = 0; fe = 0; bd = 0; tb_chk = 0; clr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = init_val(i);
        model_err = 0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_err"}, {31'b0, err}, {31'b0, model_err});
        chk({nm, "_active"}, {31'b0, active}, 32'd0);
        chk({nm, "_tx_status"}, {24'b0, tx_data}, {24'b0, st(model_err)});
    endtask

    // One whole frame: command byte, then fd[1..n]; optional coincident end.
    task automatic do_frame(input logic [7:0] cmd, input int n, input bit sim);
        logic [3:0] a;
        bit         e0, bad, rd, last, se;
        bad = (cmd[6:4] != 3'b000);
        rd  = cmd[7];
        a   = cmd[3:0];
        pulse(1, 0, 0, 8'h00, 0, 0);
        idle(1);
        e0 = model_err;
        tx_q.push_back(st(e0));
        if (bad) model_err = 1;
        else if (rd) rd_q.push_back(a);
        pulse(0, 0, 1, cmd, 1, 0);
        for (int k = 1; k <= n; k++) begin
            idle($urandom_range(3, 7));
            last = (k == n);
            se   = last && sim;
            if (bad) begin
                tx_q.push_back(st(1'b1));
            end else if (rd) begin
                tx_q.push_back(model_regs[a]);
                a = a + 4'd1;
                if (!se) rd_q.push_back(a);
            end else begin
                tx_q.push_back((k == 1) ? st(e0) : fd[k-1]);
                wr_q.push_back({a, fd[k]});
                model_regs[a] = fd[k];
                a = a + 4'd1;
            end
            pulse(0, se, 1, fd[k], 1, 0);
            if (se && !bad && !rd) cq.push_back(last_pulse_cyc + 2);
        end
        if (!(sim && n > 0)) begin
            idle($urandom_range(3, 6));
            pulse(0, 1, 0, 8'h00, 0, 0);
            if (!bad && !rd && n > 0) cq.push_back(last_pulse_cyc + 1);
        end
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cmd;
        fs = 0; fe = 0; bd = 0; clr = 0; tb_chk = 0; rx = 8'h00;
        rst = 1;
        model_reset();
        idle(3);
        rst = 0;
        chk("rst_tx", {24'b0, tx_data}, 32'h54);
        chk("rst_strobes", {29'b0, wr_en, rd_en, commit}, 32'd0);
        chk("rst_addr_data", {20'b0, wr_addr, rd_addr, wr_data}, 32'd0);
        check_idle("rst");

        // Write burst 0x05: 0x11, 0x22.
        fd[1] = 8'h11; fd[2] = 8'h22;
        do_frame(8'h05, 2, 0);
        check_idle("wr_burst");

        // Read burst from 0x0A/0x0B after loading them.
        fd[1] = 8'hAB; fd[2] = 8'hCD;
        do_frame(8'h0A, 2, 0);
        fd[1] = 8'h00; fd[2] = 8'h00;
        do_frame(8'h8A, 2, 0);
        check_idle("rd_burst");

        // Address wrap: 15, 0, 1.
        fd[1] = 8'h31; fd[2] = 8'h32; fd[3] = 8'h33;
        do_frame(8'h0F, 3, 0);

        // Bad command, then clear.
        fd[1] = 8'h99; fd[2] = 8'h98;
        do_frame(8'h30, 2, 0);
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_status", {24'b0, tx_data}, 32'h55);
        pulse(0, 0, 0, 8'h00, 0, 1);
        model_err = 0;
        idle(1);
        check_idle("clr_err");

        // Last byte coincides with frame_end at address 2.
        fd[1] = 8'h6C;
        do_frame(8'h02, 1, 1);
        check_idle("sim_end");

        // Abrupt restart: no commit for the aborted write frame.
        pulse(1, 0, 0, 8'h00, 0, 0); idle(1);
        tx_q.push_back(st(model_err));
        pulse(0, 0, 1, 8'h03, 1, 0); idle(4);
        tx_q.push_back(st(model_err));
        wr_q.push_back({4'd3, 8'h66}); model_regs[3] = 8'h66;
        pulse(0, 0, 1, 8'h66, 1, 0); idle(3);
        pulse(1, 0, 0, 8'h00, 0, 0); idle(1);
        tx_q.push_back(st(model_err)); rd_q.push_back(4'd3);
        pulse(0, 0, 1, 8'h83, 1, 0); idle(4);
        tx_q.push_back(8'h66); rd_q.push_back(4'd4);
        pulse(0, 0, 1, 8'h00, 1, 0); idle(4);
        pulse(0, 1, 0, 8'h00, 0, 0); idle(4);
        check_idle("restart");

        // Bad command with simultaneous clr_err: set wins.
        pulse(1, 0, 0, 8'h00, 0, 0); idle(1);
        tx_q.push_back(st(model_err));
        model_err = 1;
        pulse(0, 0, 1, 8'h50, 1, 1); idle(3);
        pulse(0, 1, 0, 8'h00, 0, 0); idle(3);
        check_idle("set_wins");
        pulse(0, 0, 0, 8'h00, 0, 1); model_err = 0; idle(1);

        // Reset in the middle of a read burst.
        pulse(1, 0, 0, 8'h00, 0, 0); idle(1);
        tx_q.push_back(st(model_err)); rd_q.push_back(4'hA);
        pulse(0, 0, 1, 8'h8A, 1, 0); idle(4);
        tx_q.push_back(model_regs[4'hA]); rd_q.push_back(4'hB);
        pulse(0, 0, 1, 8'h00, 1, 0);
        rst = 1; idle(2); rst = 0;
        model_reset();
        chk("midrst_tx", {24'b0, tx_data}, 32'h54);
        chk("midrst_strobes", {29'b0, wr_en, rd_en, commit}, 32'd0);
        idle(3);
        pulse(0, 0, 1, 8'h00, 0, 0); idle(5);
        check_idle("after_rst");
        fd[1] = 8'h7F;
        do_frame(8'h01, 1, 0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 9) < 7) cmd[6:4] = 3'b000;
            for (int k = 1; k < 8; k++) fd[k] = 8'($urandom);
            do_frame(cmd, $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
            check_idle("rand");
            if ($urandom_range(0, 4) == 0) begin
                pulse(0, 0, 0, 8'h00, 0, 1);
                model_err = 0;
                idle(1);
            end
        end

        idle(5);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        chk("commit_q_empty", cq.size(), 32'd0);
        chk("tx_q_empty", tx_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
